// File: rtl/spmv_hbm_stream_reader_if.sv
// Bus bundles for the HBM stream reader.
// One interface carries the AXI4 read channels (AR/R); the other carries the AXI-Stream output.
interface spmv_axi_rd_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

interface spmv_axis_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/spmv_hbm_stream_reader.sv
// AXI4 read master that streams one contiguous HBM region out as 256-bit AXI-Stream beats.
// Bursts never cross a 4 KB page, and bursts are only issued when the output FIFO can absorb them.
module spmv_hbm_stream_reader #(
  parameter int ADDR_WIDTH    = 48,
  parameter int DATA_WIDTH    = 256,
  parameter int MAX_BURST_LEN = 16,
  parameter int FIFO_DEPTH    = 64
) (
  input  logic                  axis_clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [31:0]           i_num_beats,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  spmv_axi_rd_if.master         m_axi,
  spmv_axis_if.master           m_axis
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_remaining;
  logic [31:0]           r_numBeats;
  logic [31:0]           r_outCnt;
  logic [CW-1:0]         r_credits;
  logic                  r_done;
  logic                  r_error;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW:0]           r_wrPtr;
  logic [PW:0]           r_rdPtr;

  logic [8:0] w_bndBeats;
  logic [8:0] w_remCap;
  logic [8:0] w_len;
  logic       w_busy;
  logic       w_arvalid;
  logic       w_arHs;
  logic       w_rWrite;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_tlast;
  logic       w_startOk;

  // Burst length is the smallest of the burst cap, the beats left, and the beats left in this 4 KB page.
  assign w_bndBeats = 9'd128 - {2'b00, r_addr[11:5]};
  assign w_remCap   = (r_remaining < 32'(MAX_BURST_LEN)) ? r_remaining[8:0] : 9'(MAX_BURST_LEN);
  assign w_len      = (w_bndBeats < w_remCap) ? w_bndBeats : w_remCap;

  assign w_busy    = (r_state != S_IDLE);
  assign w_arvalid = (r_state == S_ISSUE) && (32'(r_credits) >= 32'(w_len));
  assign w_arHs    = w_arvalid && m_axi.arready;
  assign w_rWrite  = m_axi.rvalid && w_busy;
  assign w_empty   = (r_wrPtr == r_rdPtr);
  assign w_full    = (r_wrPtr[PW] != r_rdPtr[PW]) && (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
  assign w_pop     = !w_empty && m_axis.tready;
  assign w_tlast   = !w_empty && (r_outCnt == r_numBeats - 32'd1);
  assign w_startOk = (r_state == S_IDLE) && i_start;

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start && (i_num_beats != 32'd0)) w_next = S_ISSUE;
      S_ISSUE: if (w_arHs && (r_remaining == 32'(w_len))) w_next = S_DRAIN;
      S_DRAIN: if (w_pop && w_tlast) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A popped beat returns one credit while an accepted burst consumes len credits; both may net out.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_numBeats  <= '0;
      r_outCnt    <= '0;
      r_credits   <= CW'(FIFO_DEPTH);
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_credits <= r_credits + CW'(w_pop) - (w_arHs ? CW'(w_len) : '0);
      if (w_startOk) begin
        r_addr      <= i_base_addr & ~ADDR_WIDTH'(31);
        r_remaining <= i_num_beats;
        r_numBeats  <= i_num_beats;
        r_outCnt    <= '0;
        r_error     <= 1'b0;
        if (i_num_beats == 32'd0) r_done <= 1'b1;
      end else begin
        if (w_arHs) begin
          r_addr      <= r_addr + (ADDR_WIDTH'(w_len) << 5);
          r_remaining <= r_remaining - 32'(w_len);
        end
        if (w_pop) r_outCnt <= r_outCnt + 32'd1;
        if (w_rWrite && (m_axi.rresp != 2'b00)) r_error <= 1'b1;
        if ((r_state == S_DRAIN) && w_pop && w_tlast) r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_rWrite) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (w_rWrite) r_mem[r_wrPtr[PW-1:0]] <= m_axi.rdata;
  end

  // Credits reserve FIFO space for every requested beat, so an R beat can never meet a full FIFO.
  assert property (@(posedge axis_clk) disable iff (rst) !(w_rWrite && w_full));

  assign m_axi.araddr  = w_arvalid ? r_addr : '0;
  assign m_axi.arlen   = w_arvalid ? 8'(w_len - 9'd1) : 8'd0;
  assign m_axi.arsize  = 3'd5;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = w_arvalid;
  assign m_axi.rready  = w_busy;

  assign m_axis.tdata  = w_empty ? '0 : r_mem[r_rdPtr[PW-1:0]];
  assign m_axis.tvalid = !w_empty;
  assign m_axis.tlast  = w_tlast;

  assign o_busy  = w_busy;
  assign o_done  = r_done;
  assign o_error = r_error;

endmodule

// File: tb/tb_spmv_hbm_stream_reader.sv
// Scoreboard bench: a page-aware burst model predicts AR bursts and the beat stream; a slave model serves HBM reads.
`timescale 1ns/1ps
module tb_spmv_hbm_stream_reader;

  localparam int AW    = 48;
  localparam int DW    = 256;
  localparam int MAXB  = 16;
  localparam int DEPTH = 64;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } burstT;
  typedef struct { logic [DW-1:0] data; logic last; } beatT;
  typedef struct { logic [AW-1:0] addr; logic last; } rBeatT;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [31:0]   numBeats;
  logic          busy;
  logic          done;
  logic          error;

  spmv_axi_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();
  spmv_axis_if   #(.DATA_WIDTH(DW))                  axis ();

  spmv_hbm_stream_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LEN(MAXB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .axis_clk(clk), .rst(rst), .i_start(start), .i_base_addr(baseAddr), .i_num_beats(numBeats),
    .o_busy(busy), .o_done(done), .o_error(error), .m_axi(axi), .m_axis(axis)
  );

  always #5 clk = ~clk;

  burstT expAr[$];
  beatT  expStream[$];
  rBeatT slvBeats[$];

  int            assertCount = 0;
  int            failCount   = 0;
  bit            slaveRandom = 0;
  int            treadyMode  = 0;
  logic [AW-1:0] errAddr     = '1;
  logic [15:0]   jobTag      = '0;
  logic          expErr      = 1'b0;
  int            reqBeats    = 0;
  int            popBeats    = 0;

  function automatic logic [DW-1:0] beatData(input logic [AW-1:0] a, input logic [15:0] tag);
    return {a, a ^ 48'h5A5A_C3C3_0F0F, ~a, a + 48'd7, a ^ {tag, tag, tag}, tag};
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: walk the region page by page, capping each burst, and list every beat in address order.
  task automatic modelJob(input logic [AW-1:0] base, input int n);
    longint a = longint'(base & ~48'h1F);
    int rem = n;
    int len;
    while (rem > 0) begin
      len = int'((64'd4096 - (a % 4096)) / 32);
      if (len > MAXB) len = MAXB;
      if (len > rem)  len = rem;
      expAr.push_back('{AW'(a), 8'(len - 1)});
      a   += longint'(len) * 32;
      rem -= len;
    end
    for (int i = 0; i < n; i++)
      expStream.push_back('{beatData((base & ~48'h1F) + AW'(32 * i), jobTag), (i == n - 1)});
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input int n, input int errIdx);
    jobTag  = 16'($urandom);
    errAddr = (errIdx >= 0) ? ((base & ~48'h1F) + AW'(32 * errIdx)) : '1;
    expErr  = (errIdx >= 0) && (errIdx < n);
    modelJob(base, n);
    @(posedge clk); #1;
    start    = 1'b1;
    baseAddr = base;
    numBeats = 32'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int cycles = 0;
    @(negedge clk);
    while (!done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("doneSeen", done, 1'b1);
    if (done) begin
      checkOutput("errorAtDone", error, expErr);
      checkOutput("busyAtDone", busy, 1'b0);
    end
  endtask

  task automatic checkIdleOutputs(input string pfx);
    checkOutput({pfx, "Busy"},    busy, 1'b0);
    checkOutput({pfx, "Done"},    done, 1'b0);
    checkOutput({pfx, "Error"},   error, 1'b0);
    checkOutput({pfx, "Arvalid"}, axi.arvalid, 1'b0);
    checkOutput({pfx, "Araddr"},  axi.araddr, '0);
    checkOutput({pfx, "Arlen"},   axi.arlen, 8'd0);
    checkOutput({pfx, "Rready"},  axi.rready, 1'b0);
    checkOutput({pfx, "Tvalid"},  axis.tvalid, 1'b0);
    checkOutput({pfx, "Tlast"},   axis.tlast, 1'b0);
    checkOutput({pfx, "Tdata"},   axis.tdata, '0);
  endtask

  // HBM slave: checks each AR against the model, then returns its beats with optional wait states.
  initial begin : slaveProc
    burstT b;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        slvBeats.delete();
        reqBeats = 0;
      end else begin
        if (axi.arvalid && axi.arready) begin
          reqBeats += int'(axi.arlen) + 1;
          if (expAr.size() == 0) checkOutput("unexpectedAr", 1'b1, 1'b0);
          else begin
            b = expAr.pop_front();
            checkOutput("araddr", axi.araddr, b.addr);
            checkOutput("arlen", axi.arlen, b.len);
          end
          checkOutput("arsize", axi.arsize, 3'd5);
          checkOutput("arburst", axi.arburst, 2'b01);
          for (int i = 0; i <= int'(axi.arlen); i++)
            slvBeats.push_back('{axi.araddr + AW'(32 * i), (i == int'(axi.arlen))});
        end
        if (axi.rvalid && axi.rready && slvBeats.size() > 0) slvBeats.delete(0);
      end
      @(posedge clk); #1;
      axi.arready = slaveRandom ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rst && slvBeats.size() > 0 && (!slaveRandom || $urandom_range(0, 3) != 0)) begin
        axi.rvalid = 1'b1;
        axi.rdata  = beatData(slvBeats[0].addr, jobTag);
        axi.rresp  = (slvBeats[0].addr == errAddr) ? 2'b10 : 2'b00;
        axi.rlast  = slvBeats[0].last;
      end else begin
        axi.rvalid = 1'b0;
        axi.rdata  = '0;
        axi.rresp  = 2'b00;
        axi.rlast  = 1'b0;
      end
    end
  end

  initial begin : treadyProc
    axis.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (treadyMode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ($urandom_range(0, 3) != 0);
        default: axis.tready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the expected stream on every handshake and expects done one cycle after tlast.
  initial begin : monitorProc
    beatT e;
    bit doneDue = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        doneDue  = 0;
        popBeats = 0;
      end else begin
        if (doneDue) begin
          checkOutput("doneAfterTlast", done, 1'b1);
          doneDue = 0;
        end
        if (axis.tvalid && axis.tready) begin
          popBeats++;
          if (expStream.size() == 0) checkOutput("unexpectedBeat", 1'b1, 1'b0);
          else begin
            e = expStream.pop_front();
            checkOutput("tdata", axis.tdata, e.data);
            checkOutput("tlast", axis.tlast, e.last);
            if (e.last) doneDue = 1;
          end
        end
        if (busy) checkOutput("creditBound", ((reqBeats - popBeats) <= DEPTH), 1'b1);
      end
    end
  end

  initial begin : mainProc
    logic [AW-1:0] base;
    int n;
    bit sawAr;
    rst = 1'b1; start = 1'b0; baseAddr = '0; numBeats = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] directed: 40 beats from 0x0, zero-wait slave");
    slaveRandom = 0; treadyMode = 0;
    applyStimulus(48'h0, 40, -1);
    @(negedge clk);
    checkOutput("arvalidLatency", axi.arvalid, 1'b1);
    waitDone(500);

    $display("[TB] directed: 4 KB boundary at 0xFC0");
    slaveRandom = 1; treadyMode = 1;
    applyStimulus(48'hFC0, 10, -1);
    waitDone(1000);

    $display("[TB] directed: tready held low with 200 beats");
    slaveRandom = 0; treadyMode = 2;
    applyStimulus(48'h0, 200, -1);
    repeat (200) @(negedge clk);
    checkOutput("stallOutstanding", 32'(reqBeats - popBeats), 32'(DEPTH));
    checkOutput("arStalled", axi.arvalid, 1'b0);
    checkOutput("stallTvalid", axis.tvalid, 1'b1);
    treadyMode = 1;
    waitDone(5000);

    $display("[TB] directed: zero-length job");
    applyStimulus({16'($urandom), 32'($urandom)}, 0, -1);
    @(negedge clk);
    checkOutput("zeroDone", done, 1'b1);
    checkOutput("zeroBusy", busy, 1'b0);
    sawAr = 0;
    for (int i = 0; i < 10; i++) begin
      if (axi.arvalid) sawAr = 1;
      @(negedge clk);
    end
    checkOutput("zeroNoAr", sawAr, 1'b0);

    $display("[TB] directed: RRESP error on beat 5, then cleared");
    slaveRandom = 1;
    applyStimulus({16'($urandom), 32'($urandom)}, 12, 5);
    waitDone(1000);
    applyStimulus({16'($urandom), 32'($urandom)}, 20, -1);
    @(negedge clk);
    checkOutput("errorCleared", error, 1'b0);
    waitDone(1000);

    $display("[TB] directed: async reset mid-burst");
    applyStimulus({16'($urandom), 32'($urandom)}, 100, -1);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkIdleOutputs("midReset");
    repeat (3) @(negedge clk);
    expAr.delete();
    expStream.delete();
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus({16'($urandom), 32'($urandom)}, 33, -1);
    waitDone(2000);

    $display("[TB] random jobs");
    for (int j = 0; j < 10; j++) begin
      base = {16'($urandom), 20'($urandom), 12'(4096 - 32 * $urandom_range(1, 24))};
      n    = $urandom_range(1, 80);
      applyStimulus(base, n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1);
      waitDone(20 * n + 200);
    end

    repeat (5) @(negedge clk);
    checkOutput("streamDrained", 32'(expStream.size()), 32'd0);
    checkOutput("arDrained", 32'(expAr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
